// File: rtl/voice_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : voice_cmd_pkg
//  Purpose  : Shared types and constants for the voice command transmitter:
//             FSM state encoding, command codes and frame geometry.
//  Revision : 1.0  initial release
// ============================================================================
package voice_cmd_pkg;

    // Transmitter FSM states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // Command codes carried in the two data bits
    localparam logic [1:0] CMD_OFF    = 2'b00;
    localparam logic [1:0] CMD_ON     = 2'b01;
    localparam logic [1:0] CMD_DIM    = 2'b10;
    localparam logic [1:0] CMD_STATUS = 2'b11;

    // Serial bits per frame: start, data1, data0, parity, stop
    localparam int FRAME_BITS = 5;

    // Even parity over the two data bits
    function automatic logic even_parity(input logic [1:0] code);
        return code[1] ^ code[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : voice_bit_timer
//  Purpose  : Loadable down-counter that stops at zero. Terminal count is
//             flagged while the count sits at zero, so loading N-1 gives a
//             span of N cycles ending on the terminal-count cycle.
//  Revision : 1.0  initial release
// ============================================================================
module voice_bit_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/voice_command_tx.sv
`default_nettype none
// ============================================================================
//  Module   : voice_command_tx
//  Purpose  : Serialises a 2-bit voice command as start/data1/data0/parity/
//             stop, each bit held BIT_CYCLES clocks, followed by GAP_CYCLES
//             forced idle-low clocks before the next command is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module voice_command_tx
    import voice_cmd_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    output logic       voice_command,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] C_BIT_LOAD = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] C_GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state_q;
    logic [1:0] shift_q;
    logic       parity_q;
    logic       bit_idx_q;
    logic       voice_command_q;
    logic       busy_q;
    logic       frame_done_q;

    logic       w_accept;
    logic       w_load;
    logic [7:0] w_load_value;
    logic [7:0] w_count;
    logic       w_tc;

    // Ready depends on state alone so a producer cannot form a loop through it
    assign cmd_ready = (state_q == S_IDLE);
    assign w_accept  = cmd_ready & cmd_valid;

    // Timer is reloaded when a frame starts and at the end of every bit;
    // the STOP->GAP hand-off loads the gap length instead of a bit length.
    assign w_load       = w_accept | ((state_q != S_IDLE) & (state_q != S_GAP) & w_tc);
    assign w_load_value = (state_q == S_STOP) ? C_GAP_LOAD : C_BIT_LOAD;

    voice_bit_timer #(
        .WIDTH (8)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (w_load),
        .load_value_i (w_load_value),
        .count_o      (w_count),
        .tc_o         (w_tc)
    );

    // Frame sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            shift_q         <= 2'b00;
            parity_q        <= 1'b0;
            bit_idx_q       <= 1'b0;
            voice_command_q <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            // Pulse lands on the final STOP cycle (count reaches zero next)
            frame_done_q <= (state_q == S_STOP) && (w_count == 8'd1);
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q         <= S_START;
                        shift_q         <= cmd_code;
                        parity_q        <= even_parity(cmd_code);
                        bit_idx_q       <= 1'b0;
                        voice_command_q <= 1'b1;
                        busy_q          <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tc) begin
                        state_q         <= S_DATA;
                        voice_command_q <= shift_q[1];
                    end
                end
                S_DATA: begin
                    if (w_tc) begin
                        if (!bit_idx_q) begin
                            bit_idx_q       <= 1'b1;
                            shift_q         <= {shift_q[0], 1'b0};
                            voice_command_q <= shift_q[0];
                        end else begin
                            bit_idx_q       <= 1'b0;
                            state_q         <= S_PARITY;
                            voice_command_q <= parity_q;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tc) begin
                        state_q         <= S_STOP;
                        voice_command_q <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_tc) begin
                        state_q         <= S_GAP;
                        voice_command_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (w_tc) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= S_IDLE;
                    voice_command_q <= 1'b0;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign voice_command = voice_command_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule
`default_nettype wire
